// File: rtl/dsp_seq_divider.sv
// dsp_seq_divider: sequential unsigned restoring divider with a one-cycle subtract mode.
// m=1 divides a by b (one quotient bit per RUN cycle, MSB first). A divisor of zero
// short-circuits to q=all ones, r=a[low half], dz=1. m=0 returns q=a-b with r=0.
// Define DSP_SEQ_DIVIDER_OUTREG_EN to add one output register stage on q, r, dz and done.
// That stage delays the result by one cycle and leaves busy unchanged.
module dsp_seq_divider #(
  localparam int DATA_WIDTH = 4,
  localparam int DIV_WIDTH  = DATA_WIDTH / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  m,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DIV_WIDTH-1:0]  b,
  output logic [DATA_WIDTH-1:0] q,
  output logic [DIV_WIDTH-1:0]  r,
  output logic                  busy,
  output logic                  done,
  output logic                  dz
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                state_r, state_s;

  // Captured operands. a_r doubles as the dividend/quotient shift register.
  logic [DATA_WIDTH-1:0] a_r;
  logic [DIV_WIDTH-1:0]  b_r;
  logic                  m_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [DIV_WIDTH:0]    pr_r;

  // Restoring-division step signals.
  logic [DIV_WIDTH:0]    shift_s, diff_s, rem_next_s;
  logic                  fits_s;
  logic                  div_step_s;
  logic                  last_s;

  // Result candidates and the result registers.
  logic [DATA_WIDTH-1:0] res_q_s;
  logic [DIV_WIDTH-1:0]  res_r_s;
  logic                  res_dz_s;
  logic [DATA_WIDTH-1:0] q_r;
  logic [DIV_WIDTH-1:0]  r_r;
  logic                  dz_r, done_r, busy_r;

  // Shift the next dividend bit into the partial remainder, then trial-subtract the divisor.
  always_comb begin
    shift_s    = (pr_r << 1'b1) | {{DIV_WIDTH{1'b0}}, a_r[DATA_WIDTH-1]};
    diff_s     = shift_s - {1'b0, b_r};
    fits_s     = (shift_s >= {1'b0, b_r});
    rem_next_s = shift_s;
    if (fits_s) begin
      rem_next_s = diff_s;
    end else begin
      rem_next_s = shift_s;
    end
  end

  // Only a true divide with a non-zero divisor iterates. Every other case finishes in one RUN cycle.
  always_comb begin
    div_step_s = m_r && (b_r != {DIV_WIDTH{1'b0}});
    last_s     = 1'b0;
    if (div_step_s) begin
      last_s = (cnt_r == CNT_W'(1));
    end else begin
      last_s = 1'b1;
    end
  end

  // Form the result that will be presented in FIN, per mode.
  always_comb begin
    res_q_s  = {DATA_WIDTH{1'b0}};
    res_r_s  = {DIV_WIDTH{1'b0}};
    res_dz_s = 1'b0;
    if (!m_r) begin
      res_q_s  = a_r - {{(DATA_WIDTH - DIV_WIDTH){1'b0}}, b_r};
      res_r_s  = {DIV_WIDTH{1'b0}};
      res_dz_s = 1'b0;
    end else if (b_r == {DIV_WIDTH{1'b0}}) begin
      res_q_s  = {DATA_WIDTH{1'b1}};
      res_r_s  = a_r[DIV_WIDTH-1:0];
      res_dz_s = 1'b1;
    end else begin
      res_q_s  = {a_r[DATA_WIDTH-2:0], fits_s};
      res_r_s  = DIV_WIDTH'(rem_next_s);
      res_dz_s = 1'b0;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> FIN after the last step, FIN -> IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = FIN;
        end else begin
          state_s = RUN;
        end
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register. Reset has priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture in IDLE and one restoring step per RUN cycle.
  // start outside IDLE is simply not looked at.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= {DATA_WIDTH{1'b0}};
      b_r   <= {DIV_WIDTH{1'b0}};
      m_r   <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
      pr_r  <= {(DIV_WIDTH + 1){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            m_r   <= m;
            cnt_r <= CNT_W'(DATA_WIDTH);
            pr_r  <= {(DIV_WIDTH + 1){1'b0}};
          end
        end
        RUN: begin
          if (div_step_s) begin
            a_r   <= {a_r[DATA_WIDTH-2:0], fits_s};
            pr_r  <= rem_next_s;
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers are captured on the edge entering FIN.
  // That keeps them valid for the whole FIN cycle, alongside done, and holds them until the next FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= {DATA_WIDTH{1'b0}};
      r_r    <= {DIV_WIDTH{1'b0}};
      dz_r   <= 1'b0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      done_r <= (state_r == RUN) && last_s;
      busy_r <= (state_s != IDLE);
      if ((state_r == RUN) && last_s) begin
        q_r  <= res_q_s;
        r_r  <= res_r_s;
        dz_r <= res_dz_s;
      end
    end
  end

  assign busy = busy_r;

`ifdef DSP_SEQ_DIVIDER_OUTREG_EN
  logic [DATA_WIDTH-1:0] q_o_r;
  logic [DIV_WIDTH-1:0]  r_o_r;
  logic                  dz_o_r, done_o_r;

  // Extra output stage: results and done arrive one cycle after FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_o_r    <= {DATA_WIDTH{1'b0}};
      r_o_r    <= {DIV_WIDTH{1'b0}};
      dz_o_r   <= 1'b0;
      done_o_r <= 1'b0;
    end else begin
      q_o_r    <= q_r;
      r_o_r    <= r_r;
      dz_o_r   <= dz_r;
      done_o_r <= done_r;
    end
  end

  assign q    = q_o_r;
  assign r    = r_o_r;
  assign dz   = dz_o_r;
  assign done = done_o_r;
`else
  assign q    = q_r;
  assign r    = r_r;
  assign dz   = dz_r;
  assign done = done_r;
`endif

endmodule

// File: tb/tb_dsp_seq_divider.sv
// tb_dsp_seq_divider: directed and random checks of dsp_seq_divider against an arithmetic model.
// Honours DSP_SEQ_DIVIDER_OUTREG_EN by expecting one extra cycle of result latency.
module tb_dsp_seq_divider;

  logic       clk = 1'b0;
  logic       rst, start, m;
  logic [3:0] a;
  logic [1:0] b;
  logic [3:0] q;
  logic [1:0] r;
  logic       busy, done, dz;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] hold_q;
  logic [1:0] hold_r;
  logic       hold_dz;

`ifdef DSP_SEQ_DIVIDER_OUTREG_EN
  localparam int OUT_LAT = 1;
`else
  localparam int OUT_LAT = 0;
`endif

  always #5 clk = ~clk;

  dsp_seq_divider dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .m    (m),
    .a    (a),
    .b    (b),
    .q    (q),
    .r    (r),
    .busy (busy),
    .done (done),
    .dz   (dz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation from its start cycle through done. The model is plain integer arithmetic.
  // inj > 0 pulses start again (with other operands) k cycles into the run.
  task automatic do_op(input logic mm, input logic [3:0] aa, input logic [1:0] bb,
                       input int inj, input string tag);
    int base;
    int k;
    logic [3:0] eq;
    logic [1:0] er;
    logic       ed;
    if (mm && bb != 2'd0) begin
      eq = 4'(int'(aa) / int'(bb));
      er = 2'(int'(aa) % int'(bb));
      ed = 1'b0;
      base = 5;
    end else if (mm) begin
      eq = 4'hF;
      er = 2'(int'(aa) % 4);
      ed = 1'b1;
      base = 2;
    end else begin
      eq = 4'((int'(aa) - int'(bb) + 16) % 16);
      er = 2'd0;
      ed = 1'b0;
      base = 2;
    end
    @(negedge clk);
    chk({tag, " idle_done"}, done, 0);
    chk({tag, " idle_busy"}, busy, 0);
    m = mm; a = aa; b = bb; start = 1'b1;
    @(negedge clk);
    k = 1;
    start = 1'b0;
    while (done !== 1'b1 && k < 20) begin
      chk({tag, " busy"}, busy, (k <= base) ? 1 : 0);
      chk({tag, " hold_q"}, q, hold_q);
      chk({tag, " hold_r"}, r, hold_r);
      chk({tag, " hold_dz"}, dz, hold_dz);
      if (k == inj) begin
        m = 1'b1; a = 4'd6; b = 2'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk({tag, " latency"}, k, base + OUT_LAT);
    chk({tag, " done"}, done, 1);
    chk({tag, " q"}, q, eq);
    chk({tag, " r"}, r, er);
    chk({tag, " dz"}, dz, ed);
    hold_q = eq; hold_r = er; hold_dz = ed;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; m = 1'b1; a = 4'd13; b = 2'd3;
    hold_q = 4'd0; hold_r = 2'd0; hold_dz = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst q", q, 0);
    chk("rst r", r, 0);
    chk("rst dz", dz, 0);
    rst = 1'b0; start = 1'b0;

    do_op(1'b1, 4'd13, 2'd3, 0, "div13_3");
    do_op(1'b1, 4'd15, 2'd1, 0, "div15_1");
    do_op(1'b1, 4'd0,  2'd2, 0, "div0_2");
    do_op(1'b1, 4'd9,  2'd0, 0, "divz9");
    do_op(1'b0, 4'd2,  2'd3, 0, "sub_wrap");
    do_op(1'b1, 4'd13, 2'd3, 2, "ignored_start");
    do_op(1'b0, 4'd15, 2'd0, 0, "sub15_0");

    // Reset sampled at edge N+3 of a divide aborts it with no done pulse.
    @(negedge clk);
    m = 1'b1; a = 4'd13; b = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort busy1", busy, 1);
    @(negedge clk);
    chk("abort hold_q", q, hold_q);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort q", q, 0);
    chk("abort r", r, 0);
    chk("abort dz", dz, 0);
    hold_q = 4'd0; hold_r = 2'd0; hold_dz = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort no_done", done, 0);
    end
    do_op(1'b1, 4'd13, 2'd3, 0, "post_rst");

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
